// File: rtl/wifi_tx_pkg.sv
// rtl/wifi_tx_pkg.sv - rate codes and puncturing keep-mask table shared by TX puncturer and RX depuncturer
package wifi_tx_pkg;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_e;

    // Number of pattern phases per rate; the reserved code behaves as rate 1/2.
    function automatic logic [1:0] phase_mod(input rate_e r);
        case (r)
            RATE_2_3: return 2'd2;
            RATE_3_4: return 2'd3;
            default:  return 2'd1;
        endcase
    endfunction

    // {keepA, keepB}; every entry keeps at least one bit.
    function automatic logic [1:0] keep_mask(input rate_e r, input logic [1:0] ph);
        case (r)
            RATE_2_3: return (ph == 2'd1) ? 2'b10 : 2'b11;
            RATE_3_4: begin
                if (ph == 2'd1)      return 2'b10;
                else if (ph == 2'd2) return 2'b01;
                else                 return 2'b11;
            end
            default:  return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/wifi_tx_punct_pattern.sv
// rtl/wifi_tx_punct_pattern.sv - combinational (rate, phase) to keep mask and next phase
module wifi_tx_punct_pattern
    import wifi_tx_pkg::*;
(
    input  rate_e      i_rate,
    input  logic [1:0] i_phase,
    output logic [1:0] o_keep,
    output logic [1:0] o_phase_next
);

    logic [1:0] w_mod;
    logic [1:0] w_phase_inc;

    always_comb begin
        w_mod        = phase_mod(i_rate);
        w_phase_inc  = i_phase + 2'd1;
        o_keep       = keep_mask(i_rate, i_phase);
        o_phase_next = (w_phase_inc >= w_mod) ? 2'd0 : w_phase_inc;
    end

endmodule

// File: rtl/wifi_tx_puncturer.sv
// rtl/wifi_tx_puncturer.sv - 802.11a puncturer: encoder pairs in, punctured serial bits out
module wifi_tx_puncturer
    import wifi_tx_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate,
    input  logic       valid_in,
    input  logic [1:0] data_in,
    input  logic       last_in,
    output logic       in_ready,
    output logic       valid_out,
    output logic       data_out,
    output logic       last_out
);

    logic [1:0] r_buf;
    logic [1:0] r_buf_last;
    logic [1:0] r_cnt;
    logic [1:0] r_phase;
    rate_e      r_rate_q;
    logic       r_frame_active;

    logic       w_accept;
    rate_e      w_rate_eff;
    logic [1:0] w_keep;
    logic [1:0] w_phase_next;
    logic [1:0] w_n_keep;
    logic [1:0] w_cnt_nxt;
    logic [1:0] w_buf_nxt;
    logic [1:0] w_last_nxt;

    assign in_ready   = enable && (r_cnt <= 2'd1);
    assign w_accept   = valid_in && in_ready;
    assign w_rate_eff = r_frame_active ? r_rate_q : rate_e'(rate);

    wifi_tx_punct_pattern u_pattern (
        .i_rate       (w_rate_eff),
        .i_phase      (r_phase),
        .o_keep       (w_keep),
        .o_phase_next (w_phase_next)
    );

    // Accept needs cnt<=1 and the head leaves the same cycle, so an accepted
    // pair always lands in an empty buffer starting at slot 0.
    always_comb begin
        w_buf_nxt  = {1'b0, r_buf[1]};
        w_last_nxt = {1'b0, r_buf_last[1]};
        w_cnt_nxt  = (r_cnt != 2'd0) ? r_cnt - 2'd1 : 2'd0;
        w_n_keep   = 2'd0;
        if (w_accept) begin
            case (w_keep)
                2'b11: begin
                    w_buf_nxt  = {data_in[0], data_in[1]};
                    w_last_nxt = {last_in, 1'b0};
                    w_n_keep   = 2'd2;
                end
                2'b10: begin
                    w_buf_nxt  = {1'b0, data_in[1]};
                    w_last_nxt = {1'b0, last_in};
                    w_n_keep   = 2'd1;
                end
                2'b01: begin
                    w_buf_nxt  = {1'b0, data_in[0]};
                    w_last_nxt = {1'b0, last_in};
                    w_n_keep   = 2'd1;
                end
                default: ;
            endcase
            w_cnt_nxt = w_n_keep;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out      <= 1'b0;
            data_out       <= 1'b0;
            last_out       <= 1'b0;
            r_buf          <= 2'b00;
            r_buf_last     <= 2'b00;
            r_cnt          <= 2'd0;
            r_phase        <= 2'd0;
            r_rate_q       <= RATE_1_2;
            r_frame_active <= 1'b0;
        end else if (enable) begin
            valid_out  <= (r_cnt != 2'd0);
            last_out   <= (r_cnt != 2'd0) && r_buf_last[0];
            if (r_cnt != 2'd0) begin
                data_out <= r_buf[0];
            end
            r_buf      <= w_buf_nxt;
            r_buf_last <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_accept) begin
                r_phase        <= last_in ? 2'd0 : w_phase_next;
                r_frame_active <= !last_in;
                if (!r_frame_active) begin
                    r_rate_q <= w_rate_eff;
                end
            end
        end else begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wifi_tx_puncturer.sv
// tb/tb_wifi_tx_puncturer.sv - self-checking bench for wifi_tx_puncturer
module tb_wifi_tx_puncturer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] rate;
    logic       valid_in;
    logic [1:0] data_in;
    logic       last_in;
    logic       in_ready;
    logic       valid_out;
    logic       data_out;
    logic       last_out;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    logic [1:0] got[$];
    int         got_cyc[$];
    logic [1:0] exp_q[$];
    bit         pa[$];
    bit         pb[$];
    bit         pl[$];
    logic [1:0] pr[$];
    bit         rdy_hist[$];

    always #5 clk = ~clk;

    wifi_tx_puncturer dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .rate      (rate),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .in_ready  (in_ready),
        .valid_out (valid_out),
        .data_out  (data_out),
        .last_out  (last_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_on && valid_out) begin
            got.push_back({data_out, last_out});
            got_cyc.push_back(cyc);
        end
    end

    task automatic clear_stim();
        pa.delete(); pb.delete(); pl.delete(); pr.delete();
        got.delete(); got_cyc.delete(); exp_q.delete(); rdy_hist.delete();
    endtask

    task automatic add_pair(input bit a, input bit b, input bit l, input logic [1:0] r);
        pa.push_back(a); pb.push_back(b); pl.push_back(l); pr.push_back(r);
    endtask

    // Reference: per-frame rate (first pair), phase pattern keeps A unless phase 2, B unless phase 1.
    task automatic build_model();
        bit act = 1'b0;
        int rq = 0;
        int ph = 0;
        exp_q.delete();
        for (int i = 0; i < pa.size(); i++) begin
            if (!act) begin
                rq  = (pr[i] == 2'd3) ? 0 : int'(pr[i]);
                act = 1'b1;
            end
            if (ph != 2 && ph != 1) begin
                exp_q.push_back({pa[i], 1'b0});
                exp_q.push_back({pb[i], pl[i]});
            end else if (ph == 1) begin
                exp_q.push_back({pa[i], pl[i]});
            end else begin
                exp_q.push_back({pb[i], pl[i]});
            end
            if (pl[i]) begin
                ph  = 0;
                act = 1'b0;
            end else begin
                ph = (ph + 1) % (rq + 1);
            end
        end
    endtask

    task automatic drive_stream(input int valid_pct, input int en_pct, input int hold_at);
        int idx = 0;
        int lim = 0;
        bit held = 1'b0;
        while (idx < pa.size() && lim < 3000) begin
            @(negedge clk);
            lim++;
            if (!held && hold_at > 0 && idx == hold_at) begin
                held = 1'b1;
                valid_in = 1'b0;
                enable = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    #1;
                    n_cmp++;
                    if (in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL hold_in_ready: got %b expected 0", in_ready);
                    end
                    @(negedge clk);
                    n_cmp++;
                    if (valid_out !== 1'b0) begin
                        n_err++;
                        $display("FAIL hold_valid_out: got %b expected 0", valid_out);
                    end
                end
            end
            enable   = ($urandom_range(99) < en_pct);
            valid_in = ($urandom_range(99) < valid_pct);
            data_in  = {pa[idx], pb[idx]};
            last_in  = pl[idx];
            rate     = pr[idx];
            #1;
            if (enable) rdy_hist.push_back(in_ready);
            if (valid_in && in_ready) idx++;
        end
        n_cmp++;
        if (idx < pa.size()) begin
            n_err++;
            $display("FAIL drive_timeout: accepted %0d expected %0d", idx, pa.size());
        end
        @(negedge clk);
        valid_in = 1'b0;
        last_in  = 1'b0;
        enable   = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; valid_in = 1'b0; data_in = 2'b00; last_in = 1'b0; rate = 2'b00;
        #13;
        n_cmp += 4;
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
        if (data_out !== 1'b0)  begin n_err++; $display("FAIL reset_data: got %b expected 0", data_out); end
        if (last_out !== 1'b0)  begin n_err++; $display("FAIL reset_last: got %b expected 0", last_out); end
        if (in_ready !== 1'b0)  begin n_err++; $display("FAIL reset_ready_dis: got %b expected 0", in_ready); end
        enable = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready_en: got %b expected 1", in_ready); end
        @(negedge clk);
        reset  = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic test_rate_half();
        logic [1:0] e[6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
        bit r[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        clear_stim();
        add_pair(1, 0, 0, 2'b00); add_pair(0, 1, 0, 2'b00); add_pair(1, 1, 1, 2'b00);
        drive_stream(100, 100, 0);
        n_cmp++;
        if (got.size() != 6) begin n_err++; $display("FAIL half_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_err++; $display("FAIL half_bit%0d: got %b expected %b", i, got[i], e[i]); end
        end
        for (int i = 0; i < 4 && i < rdy_hist.size(); i++) begin
            n_cmp++;
            if (rdy_hist[i] !== r[i]) begin n_err++; $display("FAIL half_ready%0d: got %b expected %b", i, rdy_hist[i], r[i]); end
        end
        n_cmp++;
        if (got.size() != 6 || got_cyc[5] - got_cyc[0] != 5) begin
            n_err++; $display("FAIL half_contiguous: got span %0d expected 5", got.size() == 6 ? got_cyc[5] - got_cyc[0] : -1);
        end
    endtask

    task automatic test_rate_3_4();
        logic [1:0] e[8] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b11};
        clear_stim();
        add_pair(1, 0, 0, 2'b10); add_pair(0, 1, 0, 2'b10); add_pair(1, 1, 0, 2'b10);
        add_pair(1, 0, 0, 2'b10); add_pair(0, 0, 0, 2'b10); add_pair(0, 1, 1, 2'b10);
        drive_stream(100, 100, 0);
        n_cmp++;
        if (got.size() != 8) begin n_err++; $display("FAIL r34_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_err++; $display("FAIL r34_bit%0d: got %b expected %b", i, got[i], e[i]); end
        end
        n_cmp++;
        if (got.size() != 8 || got_cyc[7] - got_cyc[0] != 7) begin
            n_err++; $display("FAIL r34_contiguous: got span %0d expected 7", got.size() == 8 ? got_cyc[7] - got_cyc[0] : -1);
        end
    endtask

    task automatic test_rate_2_3();
        logic [1:0] e[6] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
        clear_stim();
        add_pair(1, 1, 0, 2'b01); add_pair(1, 0, 0, 2'b01); add_pair(0, 1, 0, 2'b01); add_pair(0, 0, 1, 2'b01);
        drive_stream(100, 100, 0);
        n_cmp++;
        if (got.size() != 6) begin n_err++; $display("FAIL r23_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_err++; $display("FAIL r23_bit%0d: got %b expected %b", i, got[i], e[i]); end
        end
    endtask

    task automatic test_frame_end();
        logic [1:0] e[7] = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b10, 2'b10, 2'b01};
        clear_stim();
        add_pair(1, 0, 0, 2'b10); add_pair(1, 1, 1, 2'b00);
        add_pair(0, 1, 0, 2'b00); add_pair(1, 0, 1, 2'b10);
        drive_stream(100, 100, 0);
        n_cmp++;
        if (got.size() != 7) begin n_err++; $display("FAIL frame_count: got %0d expected 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_err++; $display("FAIL frame_bit%0d: got %b expected %b", i, got[i], e[i]); end
        end
    endtask

    task automatic test_hold();
        clear_stim();
        for (int i = 0; i < 6; i++) add_pair($urandom_range(1), $urandom_range(1), i == 5, 2'b00);
        build_model();
        drive_stream(100, 100, 3);
        n_cmp++;
        if (got.size() != exp_q.size()) begin n_err++; $display("FAIL hold_count: got %0d expected %0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL hold_bit%0d: got %b expected %b", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [1:0] e[3] = '{2'b00, 2'b10, 2'b11};
        @(negedge clk);
        enable = 1'b1; valid_in = 1'b1; data_in = 2'b11; last_in = 1'b0; rate = 2'b10;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_cmp += 3;
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", valid_out); end
        if (data_out !== 1'b0)  begin n_err++; $display("FAIL rst_mid_data: got %b expected 0", data_out); end
        if (last_out !== 1'b0)  begin n_err++; $display("FAIL rst_mid_last: got %b expected 0", last_out); end
        @(negedge clk);
        reset = 1'b1;
        clear_stim();
        add_pair(0, 1, 0, 2'b01); add_pair(1, 1, 1, 2'b01);
        drive_stream(100, 100, 0);
        n_cmp++;
        if (got.size() != 3) begin n_err++; $display("FAIL rst_mid_count: got %0d expected 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== e[i]) begin n_err++; $display("FAIL rst_mid_bit%0d: got %b expected %b", i, got[i], e[i]); end
        end
    endtask

    task automatic test_random(input int valid_pct, input int en_pct, input int rounds);
        for (int r = 0; r < rounds; r++) begin
            clear_stim();
            for (int f = 0; f < 3; f++) begin
                int len = $urandom_range(8, 1);
                for (int i = 0; i < len; i++)
                    add_pair($urandom_range(1), $urandom_range(1), i == len - 1, 2'($urandom_range(3)));
            end
            build_model();
            drive_stream(valid_pct, en_pct, 0);
            n_cmp++;
            if (got.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d expected %0d", r, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                n_cmp++;
                if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_bit%0d: got %b expected %b", r, i, got[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rate_half();
        test_rate_3_4();
        test_rate_2_3();
        test_frame_end();
        test_hold();
        test_reset_midframe();
        test_random(70, 85, 6);
        test_random(100, 100, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
